// File: rtl/one_hot_monitor.sv
// Registered one-hot monitor with sticky error, saturating violation counter,
// first-fault capture and a DISABLED/MONITOR/FAULT state machine.
// Optional build macro: ONE_HOT_MON_ZERO_OK_EN (all-zero sample counts as legal "no select").
module one_hot_monitor #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sig_in,
  input  logic             en,
  input  logic             clr,
  output logic             one_hot,
  output logic [IDX_W-1:0] index,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [WIDTH-1:0] fault_vec,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_DISABLED = 2'b00,
    ST_MONITOR  = 2'b01,
    ST_FAULT    = 2'b10
  } state_t;

  state_t state_q, state_d;

  logic             is_one_hot_c;
  logic             is_zero_c;
  logic             viol_c;
  logic [IDX_W-1:0] enc_c;

  // Sample classification and index encoding
  always_comb begin
    is_zero_c    = (sig_in == '0);
    is_one_hot_c = !is_zero_c && ((sig_in & (sig_in - WIDTH'(1))) == '0);
`ifdef ONE_HOT_MON_ZERO_OK_EN
    viol_c       = en && !is_one_hot_c && !is_zero_c;
`else
    viol_c       = en && !is_one_hot_c;
`endif
    enc_c = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (sig_in[i]) enc_c = IDX_W'(i);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_DISABLED: begin
        if (viol_c)  state_d = ST_FAULT;
        else if (en) state_d = ST_MONITOR;
      end
      ST_MONITOR: begin
        if (viol_c)   state_d = ST_FAULT;
        else if (!en) state_d = ST_DISABLED;
      end
      ST_FAULT: begin
        // Only a clear releases FAULT; a same-cycle violation re-enters it.
        if (clr) begin
          if (viol_c)  state_d = ST_FAULT;
          else if (en) state_d = ST_MONITOR;
          else         state_d = ST_DISABLED;
        end
      end
      default: state_d = ST_DISABLED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_DISABLED;
    else     state_q <= state_d;
  end

  assign state = state_q;

  // Verdict, sticky flag, saturating counter and first-fault capture
  always_ff @(posedge clk) begin
    if (rst) begin
      one_hot   <= 1'b0;
      index     <= '0;
      err       <= 1'b0;
      err_cnt   <= '0;
      fault_vec <= '0;
    end else begin
      if (en) begin
        one_hot <= is_one_hot_c;
        index   <= is_one_hot_c ? enc_c : '0;
      end
      if (clr) begin
        err     <= viol_c;
        err_cnt <= viol_c ? CNT_W'(1) : '0;
      end else begin
        err <= err | viol_c;
        if (viol_c && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
      end
      if (viol_c && (!err || clr)) fault_vec <= sig_in;
      else if (clr)                fault_vec <= '0;
    end
  end

endmodule

// File: tb/tb_one_hot_monitor.sv
// Scoreboard bench for one_hot_monitor: directed vectors push expected results,
// a monitor process compares each registered output set one edge later.
`timescale 1ns/1ps
module tb_one_hot_monitor;

  localparam logic [1:0] DIS = 2'b00;
  localparam logic [1:0] MON = 2'b01;
  localparam logic [1:0] FLT = 2'b10;
`ifdef ONE_HOT_MON_ZERO_OK_EN
  localparam bit ZOK = 1'b1;
`else
  localparam bit ZOK = 1'b0;
`endif

  typedef struct {
    logic       oh;
    logic [1:0] idx;
    logic       err;
    logic [7:0] cnt;
    logic [1:0] cnt_sat;
    logic [3:0] fv;
    logic [1:0] st;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sig_in = '0;
  logic       en = 1'b0;
  logic       clr = 1'b0;

  logic       one_hot, one_hot_s;
  logic [1:0] index, index_s;
  logic       err, err_s;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt_s;
  logic [3:0] fault_vec, fault_vec_s;
  logic [1:0] state, state_s;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  one_hot_monitor #(.WIDTH(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .en(en), .clr(clr),
    .one_hot(one_hot), .index(index), .err(err), .err_cnt(err_cnt),
    .fault_vec(fault_vec), .state(state)
  );

  // Small-counter instance shares stimulus to exercise saturation
  one_hot_monitor #(.WIDTH(4), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .sig_in(sig_in), .en(en), .clr(clr),
    .one_hot(one_hot_s), .index(index_s), .err(err_s), .err_cnt(err_cnt_s),
    .fault_vec(fault_vec_s), .state(state_s)
  );

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    if (got !== want) begin
      n_bad++;
      $display("FAIL vec%0d %s got %0h want %0h", n_vec, name, got, want);
    end
  endtask

  // Monitor: every edge presents a new output set
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        chk("one_hot",   8'(one_hot),   8'(e.oh));
        chk("index",     8'(index),     8'(e.idx));
        chk("err",       8'(err),       8'(e.err));
        chk("err_cnt",   err_cnt,       e.cnt);
        chk("fault_vec", 8'(fault_vec), 8'(e.fv));
        chk("state",     8'(state),     8'(e.st));
        chk("sat_cnt",   8'(err_cnt_s), 8'(e.cnt_sat));
        chk("sat_state", 8'(state_s),   8'(e.st));
      end
    end
  end

  task automatic step(input bit r, input bit c, input bit e, input logic [3:0] s,
                      input logic oh, input logic [1:0] ix, input logic er,
                      input int cnt, input logic [3:0] fv, input logic [1:0] st);
    exp_t x;
    rst = r; clr = c; en = e; sig_in = s;
    x.oh = oh; x.idx = ix; x.err = er; x.cnt = 8'(cnt);
    x.cnt_sat = (cnt > 3) ? 2'd3 : 2'(cnt);
    x.fv = fv; x.st = st;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values
    step(1, 0, 0, 4'b0000, 0, 0, 0, 0, 4'h0, DIS);
    step(1, 1, 1, 4'b1111, 0, 0, 0, 0, 4'h0, DIS);
    // Walking one
    step(0, 0, 1, 4'b0001, 1, 0, 0, 0, 4'h0, MON);
    step(0, 0, 1, 4'b0010, 1, 1, 0, 0, 4'h0, MON);
    step(0, 0, 1, 4'b0100, 1, 2, 0, 0, 4'h0, MON);
    step(0, 0, 1, 4'b1000, 1, 3, 0, 0, 4'h0, MON);
    // Disabled: inputs ignored, verdict holds
    step(0, 0, 0, 4'b1111, 1, 3, 0, 0, 4'h0, DIS);
    step(1, 0, 0, 4'b0000, 0, 0, 0, 0, 4'h0, DIS);
    step(0, 0, 0, 4'b1111, 0, 0, 0, 0, 4'h0, DIS);
    step(0, 0, 0, 4'b0000, 0, 0, 0, 0, 4'h0, DIS);
    // Violations then a legal sample: FAULT is sticky
    step(0, 0, 1, 4'b0011, 0, 0, 1, 1, 4'h3, FLT);
    step(0, 0, 1, 4'b1111, 0, 0, 1, 2, 4'h3, FLT);
    step(0, 0, 1, 4'b0001, 1, 0, 1, 2, 4'h3, FLT);
    step(0, 0, 0, 4'b0000, 1, 0, 1, 2, 4'h3, FLT);
    // Clear with same-cycle violation
    step(0, 1, 1, 4'b0110, 0, 0, 1, 1, 4'h6, FLT);
    // Clear with en=0 leaves FAULT for DISABLED
    step(0, 1, 0, 4'b1111, 0, 0, 0, 0, 4'h0, DIS);
    // Eight violations: small counter saturates at 3
    for (int i = 1; i <= 8; i++) step(0, 0, 1, 4'b1010, 0, 0, 1, i, 4'hA, FLT);
    step(0, 1, 0, 4'b0000, 0, 0, 0, 0, 4'h0, DIS);
    // Clear with no fault pending
    step(0, 0, 1, 4'b0100, 1, 2, 0, 0, 4'h0, MON);
    step(0, 1, 1, 4'b0010, 1, 1, 0, 0, 4'h0, MON);
    // All-zero sample, build-dependent
    if (ZOK) begin
      step(0, 0, 1, 4'b0000, 0, 0, 0, 0, 4'h0, MON);
      step(0, 0, 1, 4'b1000, 1, 3, 0, 0, 4'h0, MON);
    end else begin
      step(0, 0, 1, 4'b0000, 0, 0, 1, 1, 4'h0, FLT);
      step(0, 0, 1, 4'b1000, 1, 3, 1, 1, 4'h0, FLT);
    end
    // Mid-stream reset beats clr/en, then first sample evaluated normally
    step(1, 1, 1, 4'b0011, 0, 0, 0, 0, 4'h0, DIS);
    step(0, 0, 1, 4'b0001, 1, 0, 0, 0, 4'h0, MON);
    step(1, 0, 1, 4'b0001, 0, 0, 0, 0, 4'h0, DIS);
    // Direct DISABLED to FAULT
    step(0, 0, 1, 4'b0101, 0, 0, 1, 1, 4'h5, FLT);
    step(0, 0, 0, 4'b0000, 0, 0, 1, 1, 4'h5, FLT);

    repeat (3) @(posedge clk);
    #3;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
